// File: rtl/fifo_reader.sv
// Fetches words from a FIFO with a read latency of one cycle and presents them downstream with a valid/ready handshake.
// Optional macro FIFO_READER_CHECKSUM_EN adds a running XOR checksum of the transferred words.
module fifo_reader #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_rq,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       rd_count,
    output logic             underflow_err,
    output logic [WIDTH-1:0] checksum
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               rd_rq_q, rd_rq_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               start_c;
    logic               xfer_c;

    // Next-state and next-output logic; registered outputs follow the next state.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        err_d   = err_q;
        start_c = en && !fifo_empty;
        xfer_c  = (state_q == HOLD) && out_ready;

        case (state_q)
            IDLE:    if (start_c) state_d = FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: begin
                state_d = HOLD;
                data_d  = fifo_rdata;
            end
            HOLD:    if (out_ready) state_d = start_c ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase

        if (xfer_c) count_d = count_q + CNT_W'(1);
        if ((state_q == FETCH) && fifo_empty) err_d = 1'b1;

        rd_rq_d = (state_d == FETCH);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_rq_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_rq_q <= rd_rq_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

`ifdef FIFO_READER_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (xfer_c) csum_d = csum_q ^ data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign fifo_rd_rq    = rd_rq_q;
    assign out_valid     = valid_q;
    assign out_data      = data_q;
    assign rd_count      = count_q;
    assign underflow_err = err_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed, self-checking bench for fifo_reader with a one-cycle-latency FIFO model.
module tb_fifo_reader;

    localparam int unsigned W = 4;
`ifdef FIFO_READER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         fifo_empty;
    logic [W-1:0] fifo_rdata;
    logic         fifo_rd_rq;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   rd_count;
    logic         underflow_err;
    logic [W-1:0] checksum;

    fifo_reader #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_rd_rq    (fifo_rd_rq),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rd_count      (rd_count),
        .underflow_err (underflow_err),
        .checksum      (checksum)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after a read request.
    logic [W-1:0] mem [0:511];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic         force_empty = 1'b0;

    always @* fifo_empty = force_empty || (wr_ptr == rd_ptr);

    initial fifo_rdata = '0;
    always @(posedge clk) begin
        if (fifo_rd_rq) begin
            if (rd_ptr != wr_ptr) begin
                fifo_rdata <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1;
            end else begin
                fifo_rdata <= 4'hF;
            end
        end
    end

    task automatic push(input logic [W-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int w = 0; w < 20 && out_valid !== 1'b1; w++) step();
        check(name, 32'(out_valid), 32'd1);
    endtask

    function automatic logic [W-1:0] ecs(input logic [W-1:0] v);
        return CS_EN ? v : '0;
    endfunction

    typedef struct {
        logic         en;
        logic         rdy;
        logic         rq;
        logic         valid;
        logic [W-1:0] data;
        logic [7:0]   cnt;
        logic [W-1:0] cs;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic e, input logic r, input logic q, input logic v,
                                input logic [W-1:0] d, input logic [7:0] c, input logic [W-1:0] s);
        vec_t t;
        t.en = e; t.rdy = r; t.rq = q; t.valid = v; t.data = d; t.cnt = c; t.cs = s;
        return t;
    endfunction

    int           bad;
    logic [W-1:0] exp_cs;

    initial begin
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'd0, 4'h0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'h0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 8'd0, 4'h0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 8'd1, 4'h3);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 8'd1, 4'h3);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 8'd1, 4'h3);
        vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 8'd2, 4'hA);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 8'd2, 4'hA);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'hC, 8'd2, 4'hA);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'hC, 8'd3, 4'h6);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 8'd3, 4'h6);

        rst_n = 1'b1; en = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        step();
        step();
        check("reset_zero", 32'({fifo_rd_rq, out_valid, out_data, rd_count, underflow_err, checksum}), 32'd0);

        // Enabled but empty FIFO: nothing must happen.
        en = 1'b1; rst_n = 1'b1; bad = 0;
        repeat (10) begin
            step();
            if (fifo_rd_rq !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        check("empty_no_fetch", 32'(bad), 32'd0);
        check("empty_count", 32'(rd_count), 32'd0);

        // Back-to-back stream of 3,9,C via vector table.
        en = 1'b0;
        push(4'h3); push(4'h9); push(4'hC);
        step();
        for (int i = 0; i < 11; i++) begin
            en = vecs[i].en; out_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d", i),
                  32'({fifo_rd_rq, out_valid, out_data, rd_count, checksum}),
                  32'({vecs[i].rq, vecs[i].valid, vecs[i].data, vecs[i].cnt, ecs(vecs[i].cs)}));
        end

        // Stall: word 5 held for 5 cycles, then one transfer.
        push(4'h5); push(4'h7);
        en = 1'b1; out_ready = 1'b0; bad = 0;
        wait_valid("stall_valid");
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || out_data !== 4'h5 || fifo_rd_rq !== 1'b0) bad++;
            out_ready = (k == 4);
            step();
        end
        check("stall_stable", 32'(bad), 32'd0);
        check("stall_xfer", 32'({rd_count, fifo_rd_rq}), 32'({8'd4, 1'b1}));
        en = 1'b0;
        wait_valid("word7_valid");
        check("word7_data", 32'(out_data), 32'h7);
        step();
        check("word7_xfer", 32'({rd_count, out_valid, checksum}), 32'({8'd5, 1'b0, ecs(4'h4)}));

        // Clear en during CAPTURE: word still delivered, then idle with data left.
        push(4'hA); push(4'hB);
        en = 1'b1;
        step();
        check("en_fetch", 32'(fifo_rd_rq), 32'd1);
        step();
        check("en_capture", 32'({fifo_rd_rq, out_valid}), 32'd0);
        en = 1'b0;
        step();
        check("en_hold", 32'({out_valid, out_data}), 32'({1'b1, 4'hA}));
        step();
        check("en_xfer", 32'({rd_count, out_valid}), 32'({8'd6, 1'b0}));
        bad = 0;
        repeat (5) begin
            step();
            if (fifo_rd_rq !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        check("en_stay_idle", 32'(bad), 32'd0);
        check("en_fifo_left", 32'({fifo_empty, out_data}), 32'({1'b0, 4'hA}));

        // Underflow: FIFO reports empty during FETCH.
        check("err_clear", 32'(underflow_err), 32'd0);
        en = 1'b1;
        step();
        check("uf_fetch", 32'(fifo_rd_rq), 32'd1);
        force_empty = 1'b1;
        step();
        force_empty = 1'b0; en = 1'b0;
        check("uf_set", 32'(underflow_err), 32'd1);
        step();
        check("uf_present", 32'({out_valid, out_data}), 32'({1'b1, 4'hB}));
        step();
        check("uf_xfer", 32'({rd_count, underflow_err, checksum}), 32'({8'd7, 1'b1, ecs(4'h5)}));

        // Counter wrap: 249 more transfers bring the total to 256.
        exp_cs = 4'h5; bad = 0;
        for (int i = 0; i < 249; i++) push(W'(i));
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 249; i++) begin
            for (int w = 0; w < 20 && out_valid !== 1'b1; w++) step();
            if (out_valid !== 1'b1 || out_data !== W'(i)) bad++;
            exp_cs = exp_cs ^ W'(i);
            step();
        end
        check("wrap_stream", 32'(bad), 32'd0);
        check("wrap_count", 32'(rd_count), 32'd0);
        check("err_sticky", 32'(underflow_err), 32'd1);
        check("wrap_csum", 32'(checksum), 32'(ecs(exp_cs)));

        // Asynchronous reset mid-HOLD.
        out_ready = 1'b0;
        push(4'h3); push(4'h5);
        wait_valid("pre_reset_valid");
        check("pre_reset_data", 32'(out_data), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({fifo_rd_rq, out_valid, out_data, rd_count, underflow_err, checksum}), 32'd0);
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_reset", 32'({fifo_rd_rq, out_valid, rd_count}), 32'd0);
        en = 1'b1; out_ready = 1'b1;
        wait_valid("post_reset_valid");
        check("post_reset_data", 32'(out_data), 32'h5);
        step();
        check("post_reset_xfer", 32'({rd_count, checksum}), 32'({8'd1, ecs(4'h5)}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
